gauss_win_ctrl: RTL and testbench

//  Frame sequencer for the 3x3 Gaussian arithmetic block. Accepts a raster pixel stream,

---
 rtl/gauss_pkg.sv | 15 +
 rtl/gwc_line_buf.sv | 35 +++
 rtl/gauss_win_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_gauss_win_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared types for the 3x3 Gaussian window sequencer.
package gauss_pkg;

  localparam int KSIZE = 3;

  typedef logic [7:0] pixel_t;
  typedef pixel_t [8:0] win_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } gwc_state_t;

endpackage

// File: rtl/gwc_line_buf.sv
// Two-line pixel delay line: a single write port shifts line0 into line1 at
// the written column, and both lines are read back at that same column.
// Contents are not reset; they are refilled by every frame before use.
module gwc_line_buf
  import gauss_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int AW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  pixel_t        wr_data,
  output pixel_t        rd0,
  output pixel_t        rd1
);

  pixel_t line0_q [IMG_W];
  pixel_t line1_q [IMG_W];

  // Read the one- and two-lines-old pixels of the current column
  always_comb begin
    rd0 = line0_q[addr];
    rd1 = line1_q[addr];
  end

  // On write, the old line0 entry ages into line1 and the new pixel enters line0
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line1_q[addr] <= line0_q[addr];
      line0_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/gauss_win_ctrl.sv
// Frame sequencer for the 3x3 Gaussian filter: builds the sliding window from
// a raster stream and registers the filter result onto a valid/ready output.
// Optional build macro GWC_FRAME_CHECK_EN adds a sticky err output flagging
// start-while-busy and in_valid-while-idle.
module gauss_win_ctrl
  import gauss_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_pixel,
  output logic        in_ready,
  output logic [71:0] win_pixels,
  input  logic [7:0]  filt_pixel,
  output logic        out_valid,
  output logic [7:0]  out_pixel,
  input  logic        out_ready,
  output logic        busy,
  output logic        frame_done
`ifdef GWC_FRAME_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  gwc_state_t    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  win_t          win_q, win_d;
  logic          win_valid_q, win_valid_d;
  logic          out_valid_q, out_valid_d;
  pixel_t        out_pixel_q, out_pixel_d;
  logic          frame_done_q, frame_done_d;

  logic          stall;
  logic          accept;
  logic          last_px;
  pixel_t        lb0;
  pixel_t        lb1;

  gwc_line_buf #(
    .IMG_W (IMG_W),
    .AW    (CW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (col_q),
    .wr_data (in_pixel),
    .rd0     (lb0),
    .rd1     (lb1)
  );

  // Handshake qualifiers: a full window waiting on a blocked output freezes input
  always_comb begin
    stall    = win_valid_q & out_valid_q & ~out_ready;
    in_ready = (state_q == STREAM) & ~stall;
    accept   = in_valid & in_ready;
    last_px  = (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  // Next-state: FSM, raster counters, window shift and output register
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = win_valid_q;
    out_valid_d  = out_valid_q;
    out_pixel_d  = out_pixel_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          col_d   = '0;
          row_d   = '0;
        end
      end
      STREAM: begin
        if (accept && last_px) state_d = DRAIN;
      end
      DRAIN: begin
        if (!win_valid_q && !out_valid_q) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      for (int r = 0; r < KSIZE; r++) begin
        win_d[r*KSIZE]     = win_q[r*KSIZE + 1];
        win_d[r*KSIZE + 1] = win_q[r*KSIZE + 2];
      end
      win_d[2] = lb1;
      win_d[5] = lb0;
      win_d[8] = in_pixel;

      win_valid_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = last_px ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (!stall) begin
      win_valid_d = 1'b0;
    end

    if (win_valid_q && !stall) begin
      out_pixel_d = filt_pixel;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and datapath registers, all cleared on reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef GWC_FRAME_CHECK_EN
  logic err_q, err_d;

  // Sticky protocol error: start while busy, or pixels offered while idle
  always_comb begin
    err_d = err_q | (start & (state_q != IDLE)) | (in_valid & (state_q == IDLE));
  end

  // Error flag register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  // Protocol misuse (start while busy, in_valid while idle) is silently ignored.
`endif

  assign win_pixels = win_q;
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gauss_win_ctrl.sv
// Scoreboard bench for gauss_win_ctrl on a 4x4 frame with a weighted-mean filter.
module tb_gauss_win_ctrl;

  localparam int W = 4;
  localparam int H = 4;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pixel = 8'd0;
  logic        in_ready;
  logic [71:0] win_pixels;
  logic [7:0]  filt_pixel;
  logic        out_valid;
  logic [7:0]  out_pixel;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        frame_done;
`ifdef GWC_FRAME_CHECK_EN
  logic        err;
`endif

  gauss_win_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
    .win_pixels (win_pixels),
    .filt_pixel (filt_pixel),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef GWC_FRAME_CHECK_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int sb_q[$];
  int lat_q[$];
  bit lat_chk = 0;
  int rdy_mode = 0;
  int bp_cnt = 0;
  int fd_cnt = 0;
  bit saw_drop = 0;
  int img[NPIX];

  function automatic int kw(input int r, input int c);
    return ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
  endfunction

  // Stand-in for the arithmetic block: rounded 1-2-1 weighted mean of the window
  always_comb begin
    int s;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += kw(r, c) * int'(win_pixels[(r*3+c)*8 +: 8]);
    filt_pixel = 8'((s + 8) / 16);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: every interior pixel of the image, raster order
  task automatic push_expected();
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        int s;
        s = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            s += kw(dr, dc) * img[(r + dr - 1) * W + (c + dc - 1)];
        sb_q.push_back((s + 8) / 16);
      end
  endtask

  // Sink readiness pattern
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (bp_cnt < 5 && (out_valid || bp_cnt > 0)) begin
          out_ready = 1'b0;
          bp_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: pop and compare on every output handoff
  logic       held = 1'b0;
  logic [7:0] held_pix = 8'd0;
  always @(negedge clk) begin
    if (!n_rst) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) chk("held_out_pixel", out_pixel, held_pix);
      if (out_valid && !out_ready && in_valid && busy && !in_ready) saw_drop = 1;
      if (frame_done) fd_cnt++;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got=%0d required=none", out_pixel);
        end else begin
          chk("out_pixel", out_pixel, sb_q.pop_front());
        end
        if (lat_chk) begin
          if (lat_q.size() == 0) chk("latency_extra_output", cyc, -1);
          else chk("latency_cycle", cyc, lat_q.pop_front());
        end
      end
      held = out_valid && !out_ready;
      held_pix = out_pixel;
    end
  end

  task automatic feed(input int npix, input int vmode, input bit start_mid, input bit win_chk);
    int idx;
    int guard;
    bit acc;
    bit tog;
    idx = 0; guard = 0; tog = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (idx < npix && guard < 3000) begin
      in_pixel = 8'(img[idx]);
      case (vmode)
        0: in_valid = 1'b1;
        1: begin in_valid = tog; tog = !tog; end
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      start = start_mid && (idx == 5);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc && lat_chk && (idx / W) >= 2 && (idx % W) >= 2) lat_q.push_back(cyc + 2);
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
      if (acc) begin
        if (win_chk && idx == 10) begin
          chk("win1_byte0", win_pixels[7:0], 8'h00);
          chk("win1_byte4", win_pixels[39:32], 8'h11);
          chk("win1_byte8", win_pixels[71:64], 8'h22);
        end
        if (win_chk && idx == 15) begin
          chk("win4_byte0", win_pixels[7:0], 8'h11);
          chk("win4_byte8", win_pixels[71:64], 8'h33);
        end
        idx++;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (idx < npix) chk("feed_accept_timeout", idx, npix);
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int g = 0; g < 400 && !got; g++) begin
      @(negedge clk);
      if (frame_done) got = 1;
    end
    chk("frame_done_seen", got, 1);
    chk("outputs_missing", sb_q.size(), 0);
    @(negedge clk);
    chk("frame_done_width", frame_done, 0);
    chk("busy_after_frame", busy, 0);
  endtask

  task automatic run_frame(input int vmode, input int rmode, input bit start_mid,
                           input bit win_chk, input bit lat);
    push_expected();
    bp_cnt = 0;
    rdy_mode = rmode;
    lat_chk = lat;
    lat_q.delete();
    feed(NPIX, vmode, start_mid, win_chk);
    wait_done();
    if (lat) chk("latency_all_seen", lat_q.size(), 0);
    lat_chk = 0;
    rdy_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int fd_before;
    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_win_zero", (win_pixels == 72'd0), 1);
    chk("rst_out_pixel", out_pixel, 0);
`ifdef GWC_FRAME_CHECK_EN
    chk("rst_err", err, 0);
`endif
    @(posedge clk); #1 n_rst = 1'b1;

    // Constant frame
    for (int i = 0; i < NPIX; i++) img[i] = 100;
    run_frame(0, 0, 0, 0, 0);

    // Ramp frame with window inspection
    for (int i = 0; i < NPIX; i++) img[i] = (i / W) * 16 + (i % W);
    run_frame(0, 0, 0, 1, 0);

    // Backpressure at first output
    for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
    saw_drop = 0;
    run_frame(0, 2, 0, 0, 0);
    chk("in_ready_dropped_on_stall", saw_drop, 1);

    // Toggling in_valid with latency tracking
    for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
    run_frame(1, 0, 0, 0, 1);

    // Random frames with random gaps and random sink readiness
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
      run_frame(2, 1, 0, 0, 0);
    end

    // Reset mid-frame after 9 pixels
    for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
    sb_q.delete();
    feed(9, 0, 0, 0);
    fd_before = fd_cnt;
    n_rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_win_zero", (win_pixels == 72'd0), 1);
    chk("midrst_out_pixel", out_pixel, 0);
    @(posedge clk); #1 n_rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_frame_done", fd_cnt, fd_before);
    for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
    run_frame(0, 0, 0, 0, 0);

    // start pulsed during STREAM is ignored; frame completes normally
    for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
    run_frame(0, 0, 1, 0, 0);
`ifdef GWC_FRAME_CHECK_EN
    chk("err_start_while_busy", err, 1);
`endif

    // in_valid in IDLE is not accepted
    in_valid = 1'b1;
    in_pixel = 8'd55;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_no_output_pending", sb_q.size(), 0);
`ifdef GWC_FRAME_CHECK_EN
    chk("err_sticky", err, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
